// File: rtl/regfile_pkg.sv
// Shared constants, pending-counter type and width helper for the integer register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned PW_DEF   = 2;

    typedef logic [PW_DEF-1:0] pend_cnt_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_sb_read_port.sv
// One read port: write-back bypass with lowest-port priority and pending-write busy flag.
module regfile_read_port #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NWR  = 2,
    parameter int unsigned PW   = 2
) (
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     arr_data,
    input  logic [PW-1:0]       arr_cnt,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_busy
);

    int unsigned nmatch;

    always_comb begin
        rd_data = arr_data;
        nmatch  = 0;
        // Walk from the oldest port down so the youngest matching port wins.
        for (int unsigned k = 0; k < NWR; k++) begin
            int unsigned p;
            p = NWR - 1 - k;
            if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
                rd_data = wr_data[p*XLEN +: XLEN];
                nmatch  = nmatch + 1;
            end
        end
        rd_busy = (32'(arr_cnt) > nmatch);
        if (rd_addr == '0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and per-register pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN = XLEN_DEF,
    parameter  int unsigned NREG = NREG_DEF,
    parameter  int unsigned NRD  = 2,
    parameter  int unsigned NWR  = 2,
    parameter  int unsigned PW   = PW_DEF,
    localparam int unsigned AW   = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                resv_en,
    input  logic [AW-1:0]       resv_addr,
    output logic                resv_full,
    input  logic                flush,
    output logic                sb_err
);

    logic [XLEN-1:0] mem     [NREG];
    logic [PW-1:0]   cnt     [NREG];
    logic [PW-1:0]   cnt_nxt [NREG];
    logic [XLEN-1:0] wr_val  [NREG];
    logic [NREG-1:0] wr_hit;
    logic            err_nxt;

    assign resv_full = resv_en && (resv_addr != '0) && (cnt[resv_addr] == '1);

    always_comb begin
        int unsigned nmatch;
        int unsigned avail;
        wr_hit  = '0;
        err_nxt = 1'b0;
        nmatch  = 0;
        avail   = 0;
        for (int unsigned r = 0; r < NREG; r++) begin
            wr_val[r]  = '0;
            cnt_nxt[r] = '0;
            nmatch     = 0;
            for (int unsigned k = 0; k < NWR; k++) begin
                int unsigned p;
                p = NWR - 1 - k;
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
                    wr_val[r] = wr_data[p*XLEN +: XLEN];
                    nmatch    = nmatch + 1;
                end
            end
            avail = 32'(cnt[r]) +
                    ((resv_en && !resv_full && (resv_addr == AW'(r))) ? 32'd1 : 32'd0);
            // x0 never stores data and never moves its counter.
            if (r != 0) begin
                wr_hit[r] = (nmatch != 0);
                if (avail < nmatch) begin
                    err_nxt    = 1'b1;
                    cnt_nxt[r] = '0;
                end else begin
                    cnt_nxt[r] = PW'(avail - nmatch);
                end
            end
        end
        if (resv_full) err_nxt = 1'b1;
        if (flush)     err_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (wr_hit[r]) mem[r] <= wr_val[r];
                cnt[r] <= flush ? '0 : cnt_nxt[r];
            end
            if (err_nxt) sb_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
        regfile_read_port #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR),
            .PW   (PW)
        ) u_rd (
            .rd_addr  (a),
            .arr_data (mem[a]),
            .arr_cnt  (cnt[a]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[i*XLEN +: XLEN]),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule
